// File: rtl/exp_ctrl_pkg.sv
// Shared definitions for the expand-kernel write-address configuration controller:
// default widths, FSM state encoding and the bank-index width helper.
package exp_ctrl_pkg;

  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_DEPTH_W     = 6;
  localparam int DEF_DIM_W       = 7;
  localparam int DEF_NUM_BANKS   = 2;
  localparam int DEF_BANK_STRIDE = 64;
  localparam int DEF_WADDR_W     = 7;
  localparam int DEF_TOT_W       = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of a bank index; never below one bit so the port always exists.
  function automatic int bank_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/write_config_exp_ctrl_if.sv
// Bus between the layer sequencer (master) and the write-address controller (slave).
interface write_config_exp_ctrl_if
  import exp_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH_W   = DEF_DEPTH_W,
  parameter int DIM_W     = DEF_DIM_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int WADDR_W   = DEF_WADDR_W,
  parameter int TOT_W     = DEF_TOT_W
);

  localparam int BANK_W = bank_idx_w(NUM_BANKS);

  logic                start_i;
  logic                mode_3x3_i;
  logic [ADDR_W-1:0]   one_ker_addr_limit_i;
  logic [DEPTH_W-1:0]  ker_depth_i;
  logic [DIM_W-1:0]    layer_dimension_i;
  logic                chk_nxt_addr_limt_i;
  logic [WADDR_W-1:0]  wr_start_addr_o;
  logic [WADDR_W-1:0]  wr_end_addr_o;
  logic [BANK_W-1:0]   bank_sel_o;
  logic [TOT_W-1:0]    tot_addr_limit_o;
  logic                busy_o;
  logic                fire_end_flag_o;
  logic                cfg_err_o;

  modport slave (
    input  start_i, mode_3x3_i, one_ker_addr_limit_i, ker_depth_i,
           layer_dimension_i, chk_nxt_addr_limt_i,
    output wr_start_addr_o, wr_end_addr_o, bank_sel_o, tot_addr_limit_o,
           busy_o, fire_end_flag_o, cfg_err_o
  );

  modport master (
    output start_i, mode_3x3_i, one_ker_addr_limit_i, ker_depth_i,
           layer_dimension_i, chk_nxt_addr_limt_i,
    input  wr_start_addr_o, wr_end_addr_o, bank_sel_o, tot_addr_limit_o,
           busy_o, fire_end_flag_o, cfg_err_o
  );

endinterface

// File: rtl/exp_bank_rotator.sv
// Rotating bank index plus the registered base/end write addresses of the active bank.
// The address outputs trail the internal bank index by one edge.
module exp_bank_rotator
  import exp_ctrl_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int BANK_STRIDE = DEF_BANK_STRIDE,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WADDR_W     = DEF_WADDR_W,
  parameter int BANK_W      = bank_idx_w(NUM_BANKS)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic [ADDR_W-1:0]  space_i,
  output logic [BANK_W-1:0]  bank_sel_o,
  output logic [WADDR_W-1:0] wr_start_addr_o,
  output logic [WADDR_W-1:0] wr_end_addr_o
);

  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [BANK_W-1:0]  sel_q;
  logic [WADDR_W-1:0] start_q, end_q;
  logic [WADDR_W-1:0] base_d, end_d;

  // Next bank: a restart returns to bank 0, an advance steps and wraps at the last bank.
  always_comb begin
    bank_d = bank_q;
    if (clear_i) begin
      bank_d = '0;
    end else if (advance_i) begin
      bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);
    end
  end

  assign base_d = WADDR_W'(bank_q) * WADDR_W'(BANK_STRIDE);
  assign end_d  = base_d + WADDR_W'(space_i);

  // Bank index and the address registers that publish it one edge later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank_q  <= '0;
      sel_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      bank_q  <= bank_d;
      sel_q   <= bank_q;
      start_q <= base_d;
      end_q   <= end_d;
    end
  end

  assign bank_sel_o      = sel_q;
  assign wr_start_addr_o = start_q;
  assign wr_end_addr_o   = end_q;

endmodule

// File: rtl/write_config_exp_ctrl.sv
// Write-address configuration controller for the expand-kernel weight buffers.
// Latches the layer configuration on start, counts kernel depth and rows per
// bank-complete pulse, and raises the fire-end flag when the layer finishes.
module write_config_exp_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH_W     = DEF_DEPTH_W,
  parameter int DIM_W       = DEF_DIM_W,
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int BANK_STRIDE = DEF_BANK_STRIDE,
  parameter int WADDR_W     = DEF_WADDR_W,
  parameter int TOT_W       = DEF_TOT_W
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  write_config_exp_ctrl_if.slave bus
);

  localparam int BANK_W = bank_idx_w(NUM_BANKS);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  space_q, space_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DIM_W-1:0]   dim_q, dim_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  logic [DEPTH_W-1:0] ker_cnt_q, ker_cnt_d;
  logic [DIM_W-1:0]   row_cnt_q, row_cnt_d;
  logic               row_flag_q, row_flag_d;
  logic               fire_q, fire_d;
  logic               cfg_err_q, cfg_err_d;

  logic               start_ok;
  logic               start_bad;
  logic               last_row_end;
  logic               chk_ok;
  logic [TOT_W-1:0]   lim_ext;

  assign start_ok     = bus.start_i && (bus.one_ker_addr_limit_i != '0);
  assign start_bad    = bus.start_i && (bus.one_ker_addr_limit_i == '0);
  assign last_row_end = (state_q == ST_RUN) && row_flag_q && (row_cnt_q == dim_q);
  // A chk landing on the final row-end edge is dropped: the layer is over at that edge.
  assign chk_ok       = !bus.start_i && (state_q == ST_RUN) && bus.chk_nxt_addr_limt_i
                        && !last_row_end;
  assign lim_ext      = TOT_W'(bus.one_ker_addr_limit_i);

  // FSM, configuration latch and kernel/row counters; a start always wins over chk.
  always_comb begin
    state_d    = state_q;
    space_d    = space_q;
    depth_d    = depth_q;
    dim_d      = dim_q;
    tot_d      = tot_q;
    ker_cnt_d  = ker_cnt_q;
    row_cnt_d  = row_cnt_q;
    row_flag_d = row_flag_q;
    fire_d     = fire_q;
    cfg_err_d  = start_bad;
    if (start_ok) begin
      state_d    = ST_RUN;
      space_d    = bus.one_ker_addr_limit_i - ADDR_W'(1);
      depth_d    = bus.ker_depth_i;
      dim_d      = bus.layer_dimension_i;
      tot_d      = bus.mode_3x3_i ? (lim_ext << 2) - TOT_W'(1) : lim_ext - TOT_W'(1);
      ker_cnt_d  = '0;
      row_cnt_d  = '0;
      row_flag_d = 1'b0;
      fire_d     = 1'b0;
    end else if (!bus.start_i) begin
      row_flag_d = chk_ok && (ker_cnt_q == depth_q);
      if (chk_ok) begin
        ker_cnt_d = (ker_cnt_q == depth_q) ? '0 : ker_cnt_q + DEPTH_W'(1);
      end
      if ((state_q == ST_RUN) && row_flag_q) begin
        if (row_cnt_q == dim_q) begin
          row_cnt_d = '0;
          fire_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          row_cnt_d = row_cnt_q + DIM_W'(1);
        end
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      space_q    <= '0;
      depth_q    <= '0;
      dim_q      <= '0;
      tot_q      <= '0;
      ker_cnt_q  <= '0;
      row_cnt_q  <= '0;
      row_flag_q <= 1'b0;
      fire_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      space_q    <= space_d;
      depth_q    <= depth_d;
      dim_q      <= dim_d;
      tot_q      <= tot_d;
      ker_cnt_q  <= ker_cnt_d;
      row_cnt_q  <= row_cnt_d;
      row_flag_q <= row_flag_d;
      fire_q     <= fire_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  exp_bank_rotator #(
    .NUM_BANKS   (NUM_BANKS),
    .BANK_STRIDE (BANK_STRIDE),
    .ADDR_W      (ADDR_W),
    .WADDR_W     (WADDR_W),
    .BANK_W      (BANK_W)
  ) u_rotator (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .clear_i         (start_ok),
    .advance_i       (chk_ok),
    .space_i         (space_q),
    .bank_sel_o      (bus.bank_sel_o),
    .wr_start_addr_o (bus.wr_start_addr_o),
    .wr_end_addr_o   (bus.wr_end_addr_o)
  );

  assign bus.tot_addr_limit_o = tot_q;
  assign bus.busy_o           = (state_q == ST_RUN);
  assign bus.fire_end_flag_o  = fire_q;
  assign bus.cfg_err_o        = cfg_err_q;

endmodule
